seg_display_encoder: RTL

- Inverse of the team's two-digit signed 7-segment display decoder: samples the active-low segment drive of a magnitude digit and a sign digit and recovers the 4-bit two's-complement value.
- A stability filter requires STABLE_COUNT identical consecutive samples before decoding.
- The result is delivered once per stable pattern over a valid/ready handshake.
- Used as a display-readback checker and as a front-end for the scoreboard on the TRISC board harness.

---
 rtl/seg_display_encoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seg_display_encoder.sv
// seg_display_encoder
//   Reads back a two-digit signed 7-segment display and recovers the 4-bit
//   two's-complement value it shows. The segment drives are active-low.
//   A pattern is decoded only after it has been sampled STABLE_COUNT times
//   in a row. Each stable pattern is delivered once, over a valid/ready
//   handshake.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   sample_en  capture seg0/seg1 on this edge
//   seg0       magnitude digit {a,b,c,d,e,f,g}, active-low
//   seg1       sign digit {a,b,c,d,e,f,g}, active-low
//   out_ready  consumer accepts the result
//   out_valid  result available
//   value      decoded two's-complement value (4'h0 on error)
//   error      sampled pattern was not a legal encoding
//   err_count  (SEG_ENC_ERR_CNT_EN only) saturating count of accepted
//              error results
//
// Optional feature macro: SEG_ENC_ERR_CNT_EN
module seg_display_encoder #(
  parameter int STABLE_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] value,
`ifdef SEG_ENC_ERR_CNT_EN
  output logic       error,
  output logic [7:0] err_count
`else
  output logic       error
`endif
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT);

  typedef enum logic {S_TRACK, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d, cnt_upd;
  logic [13:0]   prev_q, prev_d;
  logic          done_q, done_d, done_upd;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    value_q, value_d;
  logic          error_q, error_d;
  logic [13:0]   pat;

  // Returns {error, value} for a {sign, magnitude} segment pattern.
  function automatic logic [4:0] decode(input logic [13:0] p);
    logic [3:0] m;
    logic       m_ok;
    logic [4:0] r;
    m_ok = 1'b1;
    m    = 4'd0;
    case (p[6:0])
      7'b0000001: m = 4'd0;
      7'b1001111: m = 4'd1;
      7'b0010010: m = 4'd2;
      7'b0000110: m = 4'd3;
      7'b1001100: m = 4'd4;
      7'b0100100: m = 4'd5;
      7'b0100000: m = 4'd6;
      7'b0001111: m = 4'd7;
      7'b0000000: m = 4'd8;
      default:    m_ok = 1'b0;
    endcase
    r = {1'b1, 4'h0};
    if (m_ok) begin
      if (p[13:7] == 7'b1111111 && m <= 4'd7)
        r = {1'b0, m};
      else if (p[13:7] == 7'b1111110 && m >= 4'd1)
        r = {1'b0, 4'd0 - m};  // -8 wraps to 4'b1000
    end
    return r;
  endfunction

  assign pat = {seg1, seg0};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prev_d      = prev_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    value_d     = value_q;
    error_d     = error_q;
    cnt_upd     = count_q;
    done_upd    = done_q;
    case (state_q)
      S_TRACK: begin
        if (sample_en) begin
          if (pat == prev_q) begin
            cnt_upd  = (count_q >= CNT_MAX) ? count_q : count_q + CW'(1);
            done_upd = done_q;
          end else begin
            prev_d   = pat;
            cnt_upd  = CW'(1);
            done_upd = 1'b0;
          end
          count_d = cnt_upd;
          done_d  = done_upd;
          // Emit on the sample that makes the pattern stable, once only.
          if (cnt_upd == CNT_MAX && !done_upd) begin
            {error_d, value_d} = decode(pat);
            out_valid_d        = 1'b1;
            done_d             = 1'b1;
            state_d            = S_OUT;
          end
        end
      end
      S_OUT: begin
        // Result held; prev/count/done kept so this pattern is not re-sent.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_TRACK;
        end
      end
      default: state_d = S_TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_TRACK;
      count_q     <= '0;
      prev_q      <= 14'h3FFF;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      value_q     <= 4'h0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prev_q      <= prev_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      value_q     <= value_d;
      error_q     <= error_d;
    end
  end

  assign out_valid = out_valid_q;
  assign value     = value_q;
  assign error     = error_q;

`ifdef SEG_ENC_ERR_CNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (out_valid_q && out_ready && error_q && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= 8'h00;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
